// File: rtl/quick_mem_responder.sv
// quick_mem_responder: byte-bus memory target for the quick CPU.
// A loader streams the program into the on-chip array (mode LOAD); the CPU is
// then released (cpu_run=1) and served with zero-latency reads and two-phase
// writes (mode RUN). Protocol misuse sets a sticky proto_err flag.
// Optional feature macro: QUICK_MEM_MMIO_EN adds an I/O byte at IO_ADDR.
module quick_mem_responder #(
    parameter int         DEPTH   = 32,
    parameter logic [7:0] IO_ADDR = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bus_addr,
    input  logic       bus_rd,
    input  logic       bus_wr,
    output logic [7:0] bus_rdata,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    output logic       cpu_run,
    output logic [7:0] io_out,
    input  logic [7:0] io_in,
    output logic       proto_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {M_LOAD, M_RUN}  mode_t;
    typedef enum logic {W_IDLE, W_DATA} wstate_t;

    mode_t          r_mode;
    wstate_t        r_wstate;
    wstate_t        w_wstate_next;
    logic [AW-1:0]  r_load_ptr;
    logic [7:0]     r_wr_addr;
    logic           r_proto_err;
    logic [7:0]     r_mem [DEPTH];

    logic           w_wr_latch;
    logic           w_commit;
    logic           w_proto_set;
    logic           w_io_wr;
    logic           w_mem_we;
    logic [AW-1:0]  w_mem_idx;
    logic [7:0]     w_mem_wdata;

    assign load_ready = (r_mode == M_LOAD);
    assign cpu_run    = (r_mode == M_RUN);
    assign proto_err  = r_proto_err;

    // Loader handshake: fill the array and leave LOAD on last byte or full array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= M_LOAD;
            r_load_ptr <= '0;
        end else if (r_mode == M_LOAD && load_valid) begin
            r_load_ptr <= r_load_ptr + AW'(1);
            if (load_last || r_load_ptr == AW'(DEPTH - 1)) begin
                r_mode <= M_RUN;
            end
        end
    end

    // Write FSM state, latched write address and sticky protocol flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate    <= W_IDLE;
            r_wr_addr   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_wstate <= w_wstate_next;
            if (w_wr_latch) begin
                r_wr_addr <= bus_addr;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Write FSM next state: address phase, then data phase commits.
    always_comb begin
        w_wstate_next = r_wstate;
        w_wr_latch    = 1'b0;
        w_commit      = 1'b0;
        w_proto_set   = 1'b0;
        if (r_mode == M_RUN) begin
            if (bus_rd && bus_wr) begin
                w_proto_set = 1'b1;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (bus_wr) begin
                        w_wr_latch    = 1'b1;
                        w_wstate_next = W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus_wr) begin
                        // A second address phase replaces the pending one.
                        w_proto_set   = 1'b1;
                        w_wr_latch    = 1'b1;
                        w_wstate_next = W_DATA;
                    end else begin
                        w_commit      = 1'b1;
                        w_wstate_next = W_IDLE;
                    end
                end
                default: w_wstate_next = W_IDLE;
            endcase
        end
    end

`ifdef QUICK_MEM_MMIO_EN
    logic [7:0] r_io_out;

    assign w_io_wr = w_commit && (r_wr_addr == IO_ADDR);
    assign io_out  = r_io_out;

    // Memory-mapped output register, written at the data-phase edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io_out <= '0;
        end else if (w_io_wr) begin
            r_io_out <= bus_addr;
        end
    end
`else
    logic w_unused_io;

    assign w_io_wr     = 1'b0;
    assign io_out      = '0;
    assign w_unused_io = ^{io_in, IO_ADDR, r_wr_addr};
`endif

    // Single array write port shared by the loader and the CPU data phase.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_idx   = '0;
        w_mem_wdata = '0;
        if (r_mode == M_LOAD) begin
            w_mem_we    = load_valid;
            w_mem_idx   = r_load_ptr;
            w_mem_wdata = load_data;
        end else if (w_commit) begin
            w_mem_we    = !w_io_wr;
            w_mem_idx   = r_wr_addr[AW-1:0];
            w_mem_wdata = bus_addr;
        end
    end

    // Array storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_wdata;
        end
    end

    // Zero-latency read path; idle or LOAD returns 0x00.
    always_comb begin
        bus_rdata = '0;
        if (r_mode == M_RUN && bus_rd) begin
            bus_rdata = r_mem[bus_addr[AW-1:0]];
`ifdef QUICK_MEM_MMIO_EN
            if (bus_addr == IO_ADDR) begin
                bus_rdata = io_in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_quick_mem_responder.sv
// Self-checking bench for quick_mem_responder (DEPTH=32, IO_ADDR=0xFF).
// Reference model: a plain byte array with defined-flags, plus io register.
module tb_quick_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus_addr;
    logic       bus_rd;
    logic       bus_wr;
    logic [7:0] bus_rdata;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       cpu_run;
    logic [7:0] io_out;
    logic [7:0] io_in;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_mem [32];
    bit         m_def [32];
    logic [7:0] m_io;

    quick_mem_responder #(.DEPTH(32), .IO_ADDR(8'hFF)) dut (
        .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_rd(bus_rd),
        .bus_wr(bus_wr), .bus_rdata(bus_rdata), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .cpu_run(cpu_run), .io_out(io_out), .io_in(io_in), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bus_rd = 1'b0; bus_wr = 1'b1; bus_addr = a;
        tick();
        bus_wr = 1'b0; bus_addr = d;
        tick();
`ifdef QUICK_MEM_MMIO_EN
        if (a == 8'hFF) m_io = d;
        else begin m_mem[a % 32] = d; m_def[a % 32] = 1'b1; end
`else
        m_mem[a % 32] = d; m_def[a % 32] = 1'b1;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_addr = '0; bus_rd = 1'b0; bus_wr = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0; io_in = '0;
        m_io = '0;
        for (int i = 0; i < 32; i++) m_def[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL reset_cpu_run got %b exp 0", cpu_run); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got %b exp 0", proto_err); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out got %h exp 00", io_out); end
        rst = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b exp 1", load_ready); end
    endtask

    task automatic test_load();
        logic [7:0] bytes [3];
        bytes[0] = 8'h0D; bytes[1] = 8'h1E; bytes[2] = 8'h33;
        bus_rd = 1'b1; bus_addr = 8'h01;
        #1;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL load_rd_ignored got %h exp 00", bus_rdata); end
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = bytes[i]; load_last = (i == 2);
            #1;
            checks++; if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
                errors++; $display("FAIL load_phase%0d got ready=%b run=%b exp ready=1 run=0", i, load_ready, cpu_run);
            end
            tick();
            m_mem[i] = bytes[i]; m_def[i] = 1'b1;
        end
        load_valid = 1'b0; load_last = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_fall got %b exp 0", load_ready); end
        checks++; if (cpu_run !== 1'b1) begin errors++; $display("FAIL load_cpu_run got %b exp 1", cpu_run); end
        checks++; if (bus_rdata !== 8'h1E) begin errors++; $display("FAIL load_read1 got %h exp 1e", bus_rdata); end
    endtask

    task automatic test_read();
        bus_rd = 1'b1; bus_addr = 8'h02;
        #1;
        checks++; if (bus_rdata !== 8'h33) begin errors++; $display("FAIL read_addr2 got %h exp 33", bus_rdata); end
        bus_rd = 1'b0;
        #1;
        checks++; if (bus_rdata !== 8'h00) begin errors++; $display("FAIL read_idle got %h exp 00", bus_rdata); end
    endtask

    task automatic test_write();
        do_write(8'h05, 8'hA7);
        bus_rd = 1'b1; bus_addr = 8'h05;
        #1;
        checks++; if (bus_rdata !== 8'hA7) begin errors++; $display("FAIL write_read05 got %h exp a7", bus_rdata); end
        bus_addr = 8'h25;
        #1;
        checks++; if (bus_rdata !== 8'hA7) begin errors++; $display("FAIL write_alias25 got %h exp a7", bus_rdata); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL write_proto_clean got %b exp 0", proto_err); end
        bus_rd = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] a, d, exp;
        bit         chk;
        for (int n = 0; n < 40; n++) begin
            a = 8'($urandom); d = 8'($urandom); io_in = 8'($urandom);
            bus_rd = 1'b0; bus_wr = 1'b1; bus_addr = a;
            tick();
            // Data phase with a read of address d: must see pre-write content.
            bus_wr = 1'b0; bus_addr = d; bus_rd = 1'($urandom);
            chk = bus_rd && m_def[d % 32];
            exp = m_mem[d % 32];
`ifdef QUICK_MEM_MMIO_EN
            if (bus_rd && d == 8'hFF) begin chk = 1'b1; exp = io_in; end
`endif
            #1;
            if (chk) begin
                checks++; if (bus_rdata !== exp) begin errors++; $display("FAIL rand_rd_during_commit addr=%h got %h exp %h", d, bus_rdata, exp); end
            end
            tick();
`ifdef QUICK_MEM_MMIO_EN
            if (a == 8'hFF) m_io = d;
            else begin m_mem[a % 32] = d; m_def[a % 32] = 1'b1; end
`else
            m_mem[a % 32] = d; m_def[a % 32] = 1'b1;
`endif
        end
        bus_rd = 1'b1;
        for (int n = 0; n < 32; n++) begin
            a = 8'($urandom);
            bus_addr = a;
            #1;
`ifdef QUICK_MEM_MMIO_EN
            if (a == 8'hFF) begin
                checks++; if (bus_rdata !== io_in) begin errors++; $display("FAIL rand_io_read got %h exp %h", bus_rdata, io_in); end
            end else
`endif
            if (m_def[a % 32]) begin
                checks++; if (bus_rdata !== m_mem[a % 32]) begin errors++; $display("FAIL rand_read addr=%h got %h exp %h", a, bus_rdata, m_mem[a % 32]); end
            end
        end
        bus_rd = 1'b0;
        checks++; if (io_out !== m_io) begin errors++; $display("FAIL rand_io_out got %h exp %h", io_out, m_io); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rand_proto_clean got %b exp 0", proto_err); end
    endtask

    task automatic test_proto();
        bus_rd = 1'b0; bus_wr = 1'b1; bus_addr = 8'h05;
        tick();
        bus_addr = 8'h06;
        tick();
        bus_wr = 1'b0; bus_addr = 8'h11;
        tick();
        m_mem[6] = 8'h11; m_def[6] = 1'b1;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", proto_err); end
        bus_rd = 1'b1; bus_addr = 8'h05;
        #1;
        checks++; if (bus_rdata !== m_mem[5]) begin errors++; $display("FAIL proto_mem5 got %h exp %h", bus_rdata, m_mem[5]); end
        bus_addr = 8'h06;
        #1;
        checks++; if (bus_rdata !== 8'h11) begin errors++; $display("FAIL proto_mem6 got %h exp 11", bus_rdata); end
        bus_rd = 1'b0;
    endtask

    task automatic test_mmio();
        do_write(8'h1F, 8'h77);
        do_write(8'hFF, 8'h5A);
        io_in = 8'h3C;
        bus_rd = 1'b1;
`ifdef QUICK_MEM_MMIO_EN
        checks++; if (io_out !== 8'h5A) begin errors++; $display("FAIL mmio_io_out got %h exp 5a", io_out); end
        bus_addr = 8'hFF;
        #1;
        checks++; if (bus_rdata !== 8'h3C) begin errors++; $display("FAIL mmio_io_in got %h exp 3c", bus_rdata); end
        bus_addr = 8'h1F;
        #1;
        checks++; if (bus_rdata !== 8'h77) begin errors++; $display("FAIL mmio_no_alias got %h exp 77", bus_rdata); end
`else
        bus_addr = 8'h1F;
        #1;
        checks++; if (bus_rdata !== 8'h5A) begin errors++; $display("FAIL mmio_alias got %h exp 5a", bus_rdata); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL mmio_io_tied got %h exp 00", io_out); end
`endif
        bus_rd = 1'b0;
    endtask

    task automatic test_autoload_reset();
        logic [7:0] v;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) m_def[i] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            v = 8'($urandom);
            if (i == 3 && v == 8'hEE) v = 8'h42;
            load_valid = 1'b1; load_data = v; load_last = 1'b0;
            #1;
            if (i == 31) begin
                checks++; if (load_ready !== 1'b1 || cpu_run !== 1'b0) begin
                    errors++; $display("FAIL auto_before_last got ready=%b run=%b exp 1 0", load_ready, cpu_run);
                end
            end
            tick();
            m_mem[i] = v; m_def[i] = 1'b1;
        end
        load_valid = 1'b0;
        #1;
        checks++; if (cpu_run !== 1'b1 || load_ready !== 1'b0) begin
            errors++; $display("FAIL auto_run got run=%b ready=%b exp 1 0", cpu_run, load_ready);
        end
        bus_rd = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus_addr = 8'(i);
            #1;
            checks++; if (bus_rdata !== m_mem[i]) begin errors++; $display("FAIL auto_read%0d got %h exp %h", i, bus_rdata, m_mem[i]); end
        end
        do_write(8'hFF, 8'h5A);
        bus_rd = 1'b0; bus_wr = 1'b1; bus_addr = 8'h03;
        tick();
        bus_wr = 1'b0; bus_addr = 8'hEE;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (cpu_run !== 1'b0) begin errors++; $display("FAIL rst_mid_cpu_run got %b exp 0", cpu_run); end
        checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL rst_mid_io_out got %h exp 00", io_out); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_mid_proto got %b exp 0", proto_err); end
        rst = 1'b0;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_load_ready got %b exp 1", load_ready); end
        load_valid = 1'b1; load_data = 8'h99; load_last = 1'b1;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
        m_mem[0] = 8'h99;
        bus_rd = 1'b1; bus_addr = 8'h00;
        #1;
        checks++; if (bus_rdata !== 8'h99) begin errors++; $display("FAIL rst_mid_ptr0 got %h exp 99", bus_rdata); end
        bus_addr = 8'h03;
        #1;
        checks++; if (bus_rdata !== m_mem[3]) begin errors++; $display("FAIL rst_mid_no_commit got %h exp %h", bus_rdata, m_mem[3]); end
        bus_addr = 8'h1F;
        #1;
        checks++; if (bus_rdata !== m_mem[31]) begin errors++; $display("FAIL rst_mid_mem31 got %h exp %h", bus_rdata, m_mem[31]); end
        bus_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_read();
        test_write();
        test_random();
        test_proto();
        test_mmio();
        test_autoload_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
